// File: rtl/pc_redirect_unit.sv
// Fetch-PC sequencer: it steers PCF between sequential fetch and Execute redirects,
// and holds a redirect that arrives while instruction memory is not ready.
// Optional redirect counter is enabled by defining REDIRECT_CNT_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    input  logic        StallF,
    input  logic        imemReady,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        imemReq,
    output logic        FlushD,
    output logic        FlushE,
    output logic        redirectPending,
    output logic [31:0] redirectCount
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_q, pend_d;
    logic              redirect;
    logic [XLEN-1:0]   target;

    // PCSrcE==11 is reserved and falls through as sequential.
    always_comb begin
        redirect = 1'b0;
        target   = PCTargetE;
        case (PCSrcE)
            2'b01: begin
                redirect = 1'b1;
                target   = PCTargetE;
            end
            2'b10: begin
                redirect = 1'b1;
                target   = ALUResultE & ~XLEN'(1);
            end
            default: begin
                redirect = 1'b0;
                target   = PCTargetE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state: a redirect takes priority over stall; a pending one waits only on memory.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    if (imemReady) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = PEND;
                    end
                end else if (imemReady && !StallF) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            PEND: begin
                if (redirect) begin
                    pend_d = target;
                end
                if (imemReady) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign PCF             = pc_q;
    assign PCPlus4F        = pc_q + XLEN'(4);
    assign imemReq         = rst_n;
    assign FlushE          = redirect;
    assign FlushD          = redirect || (state_q == PEND);
    assign redirectPending = (state_q == PEND);

`ifdef REDIRECT_CNT_EN
    logic [XLEN-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (redirect) begin
            cnt_q <= cnt_q + XLEN'(1);
        end
    end

    assign redirectCount = cnt_q;
`else
    assign redirectCount = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the fetch PC.
module tb_pc_redirect_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultE;
    logic        StallF;
    logic        imemReady;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        imemReq;
    logic        FlushD;
    logic        FlushE;
    logic        redirectPending;
    logic [31:0] redirectCount;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_waiting;
    logic [31:0] m_saved;
    logic [31:0] m_cnt;
    // Expected values for the current cycle
    bit          e_redir;
    logic [31:0] e_tgt;
    logic [31:0] e_plus4;
    bit          e_flushd;

    pc_redirect_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .ALUResultE(ALUResultE), .StallF(StallF), .imemReady(imemReady),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .imemReq(imemReq), .FlushD(FlushD),
        .FlushE(FlushE), .redirectPending(redirectPending), .redirectCount(redirectCount)
    );

    always #5 clk = ~clk;

    // Apply inputs, derive expectations, and move to the sampling point (falling edge).
    task automatic drive(input logic rst, input logic [1:0] src, input logic [31:0] pct,
                         input logic [31:0] alu, input logic stall, input logic ready);
        rst_n = rst; PCSrcE = src; PCTargetE = pct; ALUResultE = alu;
        StallF = stall; imemReady = ready;
        e_redir  = (src == 2'd1) || (src == 2'd2);
        e_tgt    = (src == 2'd1) ? pct : (alu - 32'(alu % 2));
        e_plus4  = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
        e_flushd = e_redir || m_waiting;
        @(negedge clk);
    endtask

    // Advance one rising edge and update the model with the same inputs.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_pc = RST_PC; m_waiting = 0; m_saved = 0; m_cnt = 0;
        end else begin
`ifdef REDIRECT_CNT_EN
            if (e_redir) m_cnt = m_cnt + 1;
`endif
            if (e_redir) m_saved = e_tgt;
            if (m_waiting || e_redir) begin
                if (imemReady) begin
                    m_pc = m_saved;
                    m_waiting = 0;
                end else begin
                    m_waiting = 1;
                end
            end else if (imemReady && !StallF) begin
                m_pc = e_plus4;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd1, 32'hDEAD_BEE0, 32'h1234_5679, 1'b0, 1'b1);
        nvec++; if (imemReq !== 1'b0) begin nerr++; $display("FAIL reset_imemReq got=%b exp=0", imemReq); end
        tick();
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        nvec++; if (PCF !== 32'h100) begin nerr++; $display("FAIL reset_pcf got=%h exp=00000100", PCF); end
        nvec++; if (redirectPending !== 1'b0 || redirectCount !== 32'h0 || imemReq !== 1'b1) begin
            nerr++; $display("FAIL reset_state pend=%b cnt=%h req=%b exp 0/0/1", redirectPending, redirectCount, imemReq);
        end
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
            nvec++; if (PCF !== exp_pc) begin nerr++; $display("FAIL seq_pcf[%0d] got=%h exp=%h", i, PCF, exp_pc); end
            nvec++; if (FlushD !== 1'b0 || FlushE !== 1'b0) begin
                nerr++; $display("FAIL seq_flush[%0d] got D=%b E=%b exp 0/0", i, FlushD, FlushE);
            end
            tick();
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 2'd1, 32'h200, 32'h0, 1'b1, 1'b1);
        nvec++; if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
            nerr++; $display("FAIL branch_flush got D=%b E=%b exp 1/1", FlushD, FlushE);
        end
        tick();
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        nvec++; if (PCF !== 32'h200) begin nerr++; $display("FAIL branch_pcf got=%h exp=00000200", PCF); end
        tick();
    endtask

    task automatic test_jalr_pending();
        drive(1'b1, 2'd2, 32'h0, 32'h305, 1'b0, 1'b0);
        nvec++; if (FlushD !== 1'b1 || FlushE !== 1'b1 || redirectPending !== 1'b0) begin
            nerr++; $display("FAIL jalr_detect got D=%b E=%b P=%b exp 1/1/0", FlushD, FlushE, redirectPending);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, (i == 1));
            nvec++; if (redirectPending !== 1'b1 || FlushD !== 1'b1 || FlushE !== 1'b0 || PCF !== 32'h200) begin
                nerr++; $display("FAIL jalr_pend[%0d] got P=%b D=%b E=%b pc=%h exp 1/1/0/00000200",
                                 i, redirectPending, FlushD, FlushE, PCF);
            end
            tick();
        end
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        nvec++; if (PCF !== 32'h304 || redirectPending !== 1'b0 || FlushD !== 1'b0) begin
            nerr++; $display("FAIL jalr_done got pc=%h P=%b D=%b exp 00000304/0/0", PCF, redirectPending, FlushD);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [1:0] seq_code;
        for (int k = 0; k < 2; k++) begin
            seq_code = (k == 0) ? 2'd0 : 2'd3;
            drive(1'b1, 2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
            tick();
            drive(1'b1, seq_code, 32'h5555_5554, 32'h0, 1'b0, 1'b1);
            nvec++; if (PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || FlushE !== 1'b0 || FlushD !== 1'b0) begin
                nerr++; $display("FAIL wrap_plus4[%0d] got pc=%h p4=%h E=%b D=%b exp fffffffc/00000000/0/0",
                                 k, PCF, PCPlus4F, FlushE, FlushD);
            end
            tick();
            drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
            nvec++; if (PCF !== 32'h0) begin nerr++; $display("FAIL wrap_pcf[%0d] got=%h exp=00000000", k, PCF); end
            tick();
        end
    endtask

    task automatic test_reset_in_pend();
        logic [31:0] exp_cnt;
        drive(1'b1, 2'd1, 32'h400, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        nvec++; if (redirectPending !== 1'b1 || imemReq !== 1'b0) begin
            nerr++; $display("FAIL rstpend_pre got P=%b req=%b exp 1/0", redirectPending, imemReq);
        end
        tick();
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
        nvec++; if (PCF !== 32'h100 || redirectPending !== 1'b0) begin
            nerr++; $display("FAIL rstpend_post got pc=%h P=%b exp 00000100/0", PCF, redirectPending);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'(1 + (i % 2)), $urandom, $urandom, 1'($urandom), 1'b1);
            tick();
        end
        drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1, 1'b1);
`ifdef REDIRECT_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        nvec++; if (redirectCount !== exp_cnt) begin
            nerr++; $display("FAIL count5 got=%0d exp=%0d", redirectCount, exp_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        logic        r;
        logic [31:0] pct;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 29) != 0);
            pct = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive(r, 2'($urandom), pct, $urandom, 1'($urandom), ($urandom_range(0, 2) != 0));
            nvec++;
            if (PCF !== m_pc || PCPlus4F !== e_plus4 || FlushE !== 1'(e_redir) || FlushD !== 1'(e_flushd) ||
                redirectPending !== 1'(m_waiting) || imemReq !== r || redirectCount !== m_cnt) begin
                nerr++;
                $display("FAIL rand[%0d] got pc=%h p4=%h E=%b D=%b P=%b req=%b cnt=%h exp pc=%h p4=%h E=%b D=%b P=%b req=%b cnt=%h",
                         i, PCF, PCPlus4F, FlushE, FlushD, redirectPending, imemReq, redirectCount,
                         m_pc, e_plus4, e_redir, e_flushd, m_waiting, r, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        m_pc = RST_PC; m_waiting = 0; m_saved = 0; m_cnt = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_jalr_pending();
        test_wrap();
        test_reset_in_pend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
